// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage data memory with fixed multi-cycle latency,
// little-endian byte addressing, pipeline stall and misalignment rejection.
module data_mem_ctrl #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  MemTypeM,
    input  logic        LoadUnsignedM,
    input  logic [63:0] ALUResultM,
    input  logic [63:0] WriteDataM,
    output logic [63:0] ReadDataM,
    output logic        MemStallM,
    output logic        MisalignM
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = LATENCY > 2 ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY >= 2 ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_addr;
    logic [1:0]      r_type;
    logic            r_uns;
    logic            r_write;
    logic [63:0]     r_wdata;
    logic [63:0]     r_rdata;
    logic            r_mis;
    logic [7:0]      r_mem [DEPTH_BYTES];

    logic            w_req;
    logic [63:0]     w_size;
    logic            w_valid;
    logic            w_idle;
    logic            w_go;
    logic            w_commit;
    logic [AW-1:0]   w_c_addr;
    logic [1:0]      w_c_type;
    logic            w_c_uns;
    logic            w_c_write;
    logic [63:0]     w_c_wdata;
    logic [63:0]     w_raw;
    logic [63:0]     w_ext;

    // Range test is written as addr <= DEPTH-size so huge addresses cannot wrap.
    assign w_req     = MemReadM | MemWriteM;
    assign w_size    = 64'd1 << MemTypeM;
    assign w_valid   = ((ALUResultM & (w_size - 64'd1)) == 64'd0) &&
                       (ALUResultM <= 64'(DEPTH_BYTES) - w_size);
    assign w_idle    = r_state == IDLE;
    assign w_go      = w_idle & w_req & w_valid;
    assign w_commit  = (w_go && LATENCY == 1) || (r_state == BUSY && r_cnt == '0);

    // With single-cycle latency the commit uses the live request, otherwise the latched one.
    assign w_c_addr  = w_idle ? ALUResultM[AW-1:0] : r_addr;
    assign w_c_type  = w_idle ? MemTypeM : r_type;
    assign w_c_uns   = w_idle ? LoadUnsignedM : r_uns;
    assign w_c_write = w_idle ? MemWriteM : r_write;
    assign w_c_wdata = w_idle ? WriteDataM : r_wdata;

    always_comb begin
        w_raw = '0;
        for (int i = 0; i < 8; i++)
            w_raw[8*i +: 8] = r_mem[w_c_addr + AW'(i)];
    end

    always_comb begin
        w_ext = w_c_type == 2'd0 ? {{56{~w_c_uns & w_raw[7]}},  w_raw[7:0]}  :
                w_c_type == 2'd1 ? {{48{~w_c_uns & w_raw[15]}}, w_raw[15:0]} :
                w_c_type == 2'd2 ? {{32{~w_c_uns & w_raw[31]}}, w_raw[31:0]} :
                                   w_raw;
    end

    assign MemStallM = w_go | (r_state == BUSY);
    assign ReadDataM = r_rdata;
    assign MisalignM = r_mis;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_mis   <= 1'b0;
        end else begin
            r_mis <= w_idle & w_req & ~w_valid;
            if (w_commit && !w_c_write)
                r_rdata <= w_ext;
            case (r_state)
                IDLE: if (w_go) begin
                    r_addr  <= ALUResultM[AW-1:0];
                    r_type  <= MemTypeM;
                    r_uns   <= LoadUnsignedM;
                    r_write <= MemWriteM;
                    r_wdata <= WriteDataM;
                    r_cnt   <= CNT_INIT;
                    r_state <= (LATENCY == 1) ? DONE : BUSY;
                end
                BUSY: if (r_cnt == '0) r_state <= DONE;
                      else r_cnt <= r_cnt - 1'b1;
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Contents survive reset; a reset on the commit edge suppresses the store.
    always_ff @(posedge clk) begin
        if (!reset && w_commit && w_c_write)
            for (int i = 0; i < 8; i++)
                if (4'(i) < (4'd1 << w_c_type))
                    r_mem[w_c_addr + AW'(i)] <= w_c_wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed and random accesses on a LATENCY=2 and a LATENCY=1
// instance, compared against a byte-array reference model.
module tb_data_mem_ctrl;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd [2];
    logic        wr [2];
    logic        uns [2];
    logic [1:0]  ty [2];
    logic [63:0] ad [2];
    logic [63:0] wd [2];
    logic [63:0] rdata [2];
    logic        stall [2];
    logic        mis [2];

    logic [7:0]  mdl [2][DEPTH];
    logic [63:0] exp_rd [2];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .LATENCY(2)) u0 (
        .clk(clk), .reset(reset), .MemReadM(rd[0]), .MemWriteM(wr[0]), .MemTypeM(ty[0]),
        .LoadUnsignedM(uns[0]), .ALUResultM(ad[0]), .WriteDataM(wd[0]),
        .ReadDataM(rdata[0]), .MemStallM(stall[0]), .MisalignM(mis[0]));

    data_mem_ctrl #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .MemReadM(rd[1]), .MemWriteM(wr[1]), .MemTypeM(ty[1]),
        .LoadUnsignedM(uns[1]), .ALUResultM(ad[1]), .WriteDataM(wd[1]),
        .ReadDataM(rdata[1]), .MemStallM(stall[1]), .MisalignM(mis[1]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0 ] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic idle_inputs(input int u);
        rd[u] = 0; wr[u] = 0; uns[u] = 0; ty[u] = 0; ad[u] = 0; wd[u] = 0;
    endtask

    task automatic model(input int u, input bit r, input bit w, input logic [1:0] t,
                         input bit un, input logic [63:0] a, input logic [63:0] d,
                         output bit valid);
        int size = 1 << t;
        logic [63:0] v = 0;
        valid = (a % 64'(size) == 0) && (a < DEPTH) && (a + 64'(size) <= DEPTH);
        if (!valid || !(r || w)) return;
        if (w) begin
            for (int i = 0; i < size; i++) mdl[u][int'(a) + i] = d[8*i +: 8];
        end else begin
            for (int i = 0; i < size; i++) v |= 64'(mdl[u][int'(a) + i]) << (8 * i);
            if (!un && size < 8 && v[8*size-1]) v |= ~((64'd1 << (8 * size)) - 1);
            exp_rd[u] = v;
        end
    endtask

    task automatic access(input int u, input bit r, input bit w, input logic [1:0] t,
                          input bit un, input logic [63:0] a, input logic [63:0] d);
        int lat = (u == 0) ? 2 : 1;
        bit valid;
        logic [63:0] prev = exp_rd[u];
        model(u, r, w, t, un, a, d, valid);
        @(negedge clk);
        rd[u] = r; wr[u] = w; ty[u] = t; uns[u] = un; ad[u] = a; wd[u] = d;
        #1 chk("stall_first", 64'(stall[u]), 64'(valid));
        if (valid) begin
            for (int k = 1; k < lat; k++) begin
                @(negedge clk);
                chk("stall_busy", 64'(stall[u]), 64'd1);
            end
            @(negedge clk);
            chk("stall_done", 64'(stall[u]), 64'd0);
            chk("rdata_done", rdata[u], exp_rd[u]);
            chk("mis_valid", 64'(mis[u]), 64'd0);
            idle_inputs(u);
        end else begin
            @(negedge clk);
            chk("mis_pulse", 64'(mis[u]), 64'd1);
            chk("stall_rej", 64'(stall[u]), 64'd0);
            chk("rdata_rej", rdata[u], prev);
            idle_inputs(u);
            @(negedge clk);
            chk("mis_end", 64'(mis[u]), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] a, d, pre;
        logic [1:0] t;
        int sel;
        reset = 1;
        idle_inputs(0); idle_inputs(1);
        exp_rd[0] = 0; exp_rd[1] = 0;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_rdata", rdata[u], 64'd0);
            chk("rst_stall", 64'(stall[u]), 64'd0);
            chk("rst_mis", 64'(mis[u]), 64'd0);
        end
        reset = 0;
        // fill both memories; unit 1 uses read+write together so the store must win
        for (int i = 0; i < DEPTH; i += 8) begin
            access(0, 0, 1, 2'd3, 0, 64'(i), {$urandom, $urandom});
            access(1, 1, 1, 2'd3, 0, 64'(i), {$urandom, $urandom});
        end
        access(0, 0, 1, 2'd3, 0, 64'h10, 64'h1122334455667788);
        access(0, 1, 0, 2'd3, 0, 64'h10, 64'h0);
        chk("dbl_value", rdata[0], 64'h1122334455667788);
        access(0, 0, 1, 2'd0, 0, 64'h21, 64'h80);
        access(0, 1, 0, 2'd0, 0, 64'h21, 64'h0);
        chk("byte_signed", rdata[0], 64'hFFFFFFFFFFFFFF80);
        access(0, 1, 0, 2'd0, 1, 64'h21, 64'h0);
        chk("byte_unsigned", rdata[0], 64'h0000000000000080);
        access(0, 1, 0, 2'd0, 1, 64'h20, 64'h0);
        access(0, 1, 0, 2'd0, 1, 64'h22, 64'h0);
        access(0, 1, 0, 2'd2, 0, 64'h22, 64'h0);
        access(0, 0, 1, 2'd3, 0, DEPTH - 4, 64'hDEADBEEFCAFEF00D);
        access(0, 1, 0, 2'd2, 1, DEPTH - 4, 64'h0);
        access(0, 1, 0, 2'd0, 0, DEPTH, 64'h0);
        access(0, 0, 1, 2'd3, 0, 64'hFFFFFFFFFFFFFFF8, 64'h1);
        access(0, 1, 0, 2'd3, 0, DEPTH - 8, 64'h0);
        // abort a store with reset while it is in flight
        pre = {mdl[0][8'h47], mdl[0][8'h46], mdl[0][8'h45], mdl[0][8'h44],
               mdl[0][8'h43], mdl[0][8'h42], mdl[0][8'h41], mdl[0][8'h40]};
        @(negedge clk);
        wr[0] = 1; ty[0] = 2'd3; ad[0] = 64'h40; wd[0] = 64'hA5A5A5A5A5A5A5A5;
        #1 chk("rst_store_stall", 64'(stall[0]), 64'd1);
        @(negedge clk);
        chk("rst_store_busy", 64'(stall[0]), 64'd1);
        reset = 1;
        idle_inputs(0);
        @(negedge clk);
        reset = 0;
        exp_rd[0] = 0; exp_rd[1] = 0;
        for (int u = 0; u < 2; u++) begin
            chk("abort_rdata", rdata[u], 64'd0);
            chk("abort_stall", 64'(stall[u]), 64'd0);
            chk("abort_mis", 64'(mis[u]), 64'd0);
        end
        access(0, 1, 0, 2'd3, 0, 64'h40, 64'h0);
        chk("abort_kept", rdata[0], pre);
        access(1, 1, 0, 2'd1, 0, 64'h32, 64'h0);
        access(1, 1, 1, 2'd2, 0, 64'h30, 64'h00000000FFFF8001);
        access(1, 1, 0, 2'd2, 0, 64'h30, 64'h0);
        chk("lat1_word", rdata[1], 64'hFFFFFFFFFFFF8001);
        for (int n = 0; n < 160; n++) begin
            int u = (n % 3 == 2) ? 1 : 0;
            t = 2'($urandom_range(3));
            a = 64'($urandom_range(DEPTH - 1));
            if ($urandom_range(3) != 0) a &= ~((64'd1 << t) - 1);
            if ($urandom_range(15) == 0) a = DEPTH + 64'($urandom_range(16));
            d = {$urandom, $urandom};
            sel = $urandom_range(2);
            access(u, sel != 1, sel != 0, t, 1'($urandom_range(1)), a, d);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
